// File: rtl/alu4_reg.sv
// Registered ALU: bitwise, add/sub and unsigned set-less-than with a one-cycle result latency.
// The result and its carry/zero flags load only on valid cycles; out-valid follows in-valid on every edge.
module alu4_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_opcode,
  output logic [WIDTH-1:0] o_y,
  output logic             o_carry,
  output logic             o_zero,
  output logic             o_valid
);

  logic [WIDTH-1:0] w_bb;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_y_next;
  logic             w_carry_next;
  logic             w_zero_next;

  logic [WIDTH-1:0] r_y;
  logic             r_carry;
  logic             r_zero;
  logic             r_valid;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_binv
      assign w_bb[gi] = i_b[gi] ^ i_opcode[2];
    end
  endgenerate

  // opcode[2] both inverts B and injects the +1, so one adder serves add, sub and compare.
  assign w_sum = {1'b0, i_a} + {1'b0, w_bb} + {{WIDTH{1'b0}}, i_opcode[2]};

  always_comb begin
    w_y_next     = '0;
    w_carry_next = 1'b0;
    case (i_opcode[1:0])
      2'b00: w_y_next = i_a & w_bb;
      2'b01: w_y_next = i_a | w_bb;
      2'b10: begin
        w_y_next     = w_sum[WIDTH-1:0];
        w_carry_next = w_sum[WIDTH];
      end
      default: begin
        // A missing carry on a + ~b + 1 means a borrow, i.e. a < b.
        if (i_opcode[2]) begin
          w_y_next[0]  = ~w_sum[WIDTH];
          w_carry_next = w_sum[WIDTH];
        end
      end
    endcase
  end

  assign w_zero_next = (w_y_next == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y     <= '0;
      r_carry <= 1'b0;
      r_zero  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_y     <= w_y_next;
        r_carry <= w_carry_next;
        r_zero  <= w_zero_next;
      end
    end
  end

  assign o_y     = r_y;
  assign o_carry = r_carry;
  assign o_zero  = r_zero;
  assign o_valid = r_valid;

endmodule

// File: tb/tb_alu4_reg.sv
// Directed bench for alu4_reg: expectations from an opcode-level reference model are queued on
// drive and popped one edge later against the registered outputs.
module tb_alu4_reg;

  localparam int W = 4;

  typedef struct packed {
    logic [W-1:0] y;
    logic         carry;
    logic         zero;
    logic         valid;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0]   opcode = '0;
  logic [W-1:0] y;
  logic         carry;
  logic         zero;
  logic         out_valid;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];
  exp_t held;

  alu4_reg #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_valid  (in_valid),
    .i_a      (a),
    .i_b      (b),
    .i_opcode (opcode),
    .o_y      (y),
    .o_carry  (carry),
    .o_zero   (zero),
    .o_valid  (out_valid)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                 input logic [2:0] op);
    exp_t e;
    logic [W:0] s;
    e = '0;
    case (op)
      3'b000: e.y = fa & fb;
      3'b001: e.y = fa | fb;
      3'b010: begin s = {1'b0, fa} + {1'b0, fb}; e.y = s[W-1:0]; e.carry = s[W]; end
      3'b011: e.y = '0;
      3'b100: e.y = fa & ~fb;
      3'b101: e.y = fa | ~fb;
      3'b110: begin e.y = fa - fb; e.carry = (fa >= fb); end
      default: begin e.y = (fa < fb) ? 1 : 0; e.carry = (fa >= fb); end
    endcase
    e.zero  = (e.y == '0);
    e.valid = 1'b1;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".y"},     y,                  e.y);
    chk({tag, ".carry"}, {{(W-1){1'b0}}, carry},     {{(W-1){1'b0}}, e.carry});
    chk({tag, ".zero"},  {{(W-1){1'b0}}, zero},      {{(W-1){1'b0}}, e.zero});
    chk({tag, ".valid"}, {{(W-1){1'b0}}, out_valid}, {{(W-1){1'b0}}, e.valid});
    $display("op %s y=%b c=%b z=%b v=%b", tag, y, carry, zero, out_valid);
  endtask

  // Drive on the falling edge, push the expectation, pop and compare just after the rising edge.
  task automatic issue(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic [2:0] op, input logic v);
    exp_t e;
    @(negedge clk);
    a = ta; b = tb_; opcode = op; in_valid = v;
    if (v) begin
      held = model(ta, tb_, op);
    end
    e = held;
    e.valid = v;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s scoreboard empty observed 0 expected 1", tag);
    end else begin
      chk_all(tag, sb_q.pop_front());
    end
  endtask

  initial begin
    held = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_init", '0);

    @(negedge clk);
    rst_n = 1'b1;

    issue("and_000", 4'b0110, 4'b0110, 3'b000, 1'b1);
    issue("or_001",  4'b1010, 4'b0010, 3'b001, 1'b1);
    issue("andn_100",4'b0011, 4'b0001, 3'b100, 1'b1);
    issue("orn_101", 4'b0000, 4'b0001, 3'b101, 1'b1);
    issue("add_a",   4'b1000, 4'b0011, 3'b010, 1'b1);
    issue("add_b",   4'b0001, 4'b0101, 3'b010, 1'b1);
    issue("add_wrap",4'b1111, 4'b0001, 3'b010, 1'b1);
    issue("sub_a",   4'b0100, 4'b0001, 3'b110, 1'b1);
    issue("sub_eq",  4'b0010, 4'b0010, 3'b110, 1'b1);
    issue("sub_brw", 4'b0000, 4'b0001, 3'b110, 1'b1);
    issue("slt_lt",  4'b0110, 4'b0111, 3'b111, 1'b1);
    issue("slt_eq",  4'b0011, 4'b0011, 3'b111, 1'b1);
    issue("slt_gt",  4'b0101, 4'b0010, 3'b111, 1'b1);
    issue("add_c1",  4'b1001, 4'b1000, 3'b010, 1'b1);
    issue("unused",  4'b0001, 4'b0110, 3'b011, 1'b1);
    issue("slt_lt2", 4'b0000, 4'b1111, 3'b111, 1'b1);
    issue("hold_a",  4'b1111, 4'b1111, 3'b001, 1'b0);
    issue("hold_b",  4'b0101, 4'b1010, 3'b110, 1'b0);
    issue("b2b_1",   4'b1100, 4'b1010, 3'b000, 1'b1);
    issue("b2b_2",   4'b1100, 4'b1010, 3'b001, 1'b1);
    issue("b2b_3",   4'b0111, 4'b0110, 3'b110, 1'b1);

    // Asynchronous reset with a valid op in flight: outputs clear without waiting for an edge.
    @(negedge clk);
    a = 4'b1111; b = 4'b0001; opcode = 3'b010; in_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk_all("rst_async", '0);
    @(posedge clk);
    #1;
    chk_all("rst_held", '0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    held = '0;
    @(posedge clk);
    #1;
    chk_all("rst_idle", '0);
    issue("post_rst", 4'b0011, 4'b0100, 3'b010, 1'b1);

    if (sb_q.size() != 0) begin
      checks++; errors++;
      $error("FAIL sb_leftover observed %0d expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
